// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: start-bit validation at mid-bit, centre sampling of data and stop
// bits, and a valid/ready output with one-cycle framing-error and overrun pulses.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_sync,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] data_out_reg, data_out_next;
    logic                 data_valid_reg, data_valid_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 overrun_reg, overrun_next;
    logic                 busy_reg, busy_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            shift_reg      <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            shift_reg      <= shift_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
            overrun_reg    <= overrun_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        shift_next      = shift_reg;
        data_out_next   = data_out_reg;
        data_valid_next = data_valid_reg;
        frame_err_next  = 1'b0;
        overrun_next    = 1'b0;

        // Consumer handshake; a load at the stop sample below may re-set valid.
        if (data_valid_reg && data_ready) begin
            data_valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (!rx_sync) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == CNT_HALF) begin
                    if (!rx_sync) begin
                        state_next = DATA;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    shift_next                = shift_reg >> 1;
                    shift_next[DATA_BITS-1]   = rx_sync;
                    cnt_next                  = '0;
                    idx_next                  = idx_reg + 1'b1;
                    if (idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (rx_sync) begin
                        if (!data_valid_reg || data_ready) begin
                            data_out_next   = shift_reg;
                            data_valid_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;
    assign busy       = busy_reg;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- UART receive controller that sequences the synchronized rx line from the 2-stage synchronizer into 8N1 bytes.
- Detects the start bit, validates it at mid-bit, samples data bits LSB first at bit centres, and checks the stop bit.
- Presents each byte on a valid/ready handshake to the downstream core.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per UART bit (50 MHz / 115200). Legal values are 4 or more.
- DATA_BITS, 8: data bits per frame.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_sync  input  1  rx line after the synchronizer; idle high.
- data_out  output  DATA_BITS  received byte, LSB = first data bit.
- data_valid  output  1  data_out holds an unconsumed byte.
- data_ready  input  1  consumer accepts data_out when it is high together with data_valid.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a frame completed while the previous byte was still pending, and the new byte was dropped.
- busy  output  1  high in START, DATA or STOP.

Behaviour:
- Reset, sampled on clk while rst=1:
  - state=IDLE; bit counter=0; bit index=0; shift register=0.
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame discards the partial frame and clears any pending byte.
  - The first state after reset is IDLE; the line must be seen low again before a new frame is started.
- Counter width: $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, integer division.
- IDLE:
  - When rx_sync=0, go to START and set counter=0.
  - Otherwise stay in IDLE.
- START:
  - Counter increments each cycle.
  - At counter==HALF-1, sample rx_sync:
    - 0: go to DATA, counter=0, bit index=0.
    - 1: treat as a glitch and return to IDLE. No flags are raised.
- DATA:
  - Counter increments each cycle.
  - At counter==CLKS_PER_BIT-1:
    - Shift rx_sync into the shift register MSB, shifting right so the first bit ends at the LSB.
    - Set counter=0 and increment bit index.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - At counter==CLKS_PER_BIT-1, sample rx_sync, then go to IDLE.
  - Stop bit = 1:
    - If data_valid=0, or data_valid=1 with data_ready=1 in the same cycle: load data_out from the shift register and set data_valid=1 on the next edge.
    - If data_valid=1 with data_ready=0: keep the old data_out and data_valid, drop the new byte, and pulse overrun.
  - Stop bit = 0: pulse frame_err and leave data_out and data_valid unchanged.
- Sample timing:
  - Data bit n (0-based) is sampled (n+1)*CLKS_PER_BIT cycles after the start validation sample.
  - The stop bit is sampled (DATA_BITS+1)*CLKS_PER_BIT cycles after the start validation sample.
  - data_valid rises on the edge after the stop sample cycle.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets the next start edge be detected with no lost frame.
- Handshake:
  - data_valid holds until the cycle in which data_valid&data_ready=1; it clears on the next edge.
  - data_out is stable while data_valid=1.
  - data_ready while data_valid=0 has no effect.
  - Simultaneous accept and new-byte load: data_valid stays 1 and data_out takes the new byte. No overrun.
- Flag outputs: frame_err and overrun are registered, exactly one cycle wide, and never asserted in the same cycle.
- busy is a registered decode of the state, so it is high exactly while the state is START, DATA or STOP.
- rx_sync changes in IDLE other than a low level are ignored. There is no break detection.

Test Plan:
- Single frame (CLKS_PER_BIT=16): drive 0xA5 as 8N1 with data_ready=0 -> data_out=0xA5 and data_valid=1, first asserted 1+8+16*9+1 cycles after the falling edge. data_valid then holds. Pulse data_ready for 1 cycle -> data_valid=0 on the next cycle.
- Start glitch: hold rx_sync low for 3 cycles, then high -> back in IDLE after the HALF-1 sample. busy high for 8 cycles. No data_valid, frame_err or overrun.
- Framing error: send 0x3C with the stop bit low -> frame_err pulses for exactly 1 cycle, data_valid stays 0, and the next good frame 0x81 is received correctly.
- Overrun: send 0x11, keep data_ready=0, then send 0x22 -> overrun pulses once and data_out stays 0x11. With data_ready=1 held throughout, frames 0x11 and 0x22 sent back-to-back (stop bit directly followed by the next start) -> both delivered, no overrun.
- Simultaneous accept and load: assert data_ready on the exact stop-sample cycle of the second frame -> data_valid stays 1, data_out changes 0x11->0x22, overrun=0.
- Reset mid-frame: assert rst during DATA bit 4 of 0xFF -> all outputs 0 on the next cycle. Release rst with rx_sync high -> no spurious byte. A following 0x5A is received correctly.
